btb_predictor: RTL and testbench
================================

Name: btb_predictor

Overview:
- Parametrised direct-mapped branch target buffer with per-entry saturating direction counters.
- Sits between IF and EX of the MIPS pipeline.
- IF side: looks up the fetch PC combinationally and returns a predicted direction and target.
- EX side: each resolved conditional branch trains the table. The block computes the branch target internally from PC and the 16-bit offset, so EX does not supply a target.

Parameters:
- IDX_W, 6, index bits; table has 2^IDX_W entries; index = pc[IDX_W+1:2].
- TAG_W, 8, partial tag bits; tag = pc[IDX_W+TAG_W+1:IDX_W+2]. Legal only if IDX_W+TAG_W <= 30.
- CNT_W, 2, direction counter width, 1 or 2. Predict taken when counter MSB = 1.

Ports:
- clk  in  1  rising-edge clock.
- resetn  in  1  asynchronous active-low reset.
- if_pc  in  32  fetch PC to look up.
- pred_hit  out  1  valid entry with matching tag at index(if_pc).
- pred_taken  out  1  pred_hit & counter MSB.
- pred_target  out  32  stored target if pred_taken, else if_pc + 4.
- ex_valid  in  1  EX holds a resolved conditional branch this cycle; sample on clk rising edge.
- ex_pc  in  32  PC of the resolved branch.
- ex_offset  in  16  raw immediate of the branch.
- ex_taken  in  1  actual branch outcome.
- flush_all  in  1  invalidate the entire table.
- upd_mispredict  out  1  registered; 1 for one cycle after an update whose table prediction was wrong.

Behaviour:
- Reset (resetn = 0, asynchronous):
  - All valid bits = 0.
  - All counters = 0; tags and targets don't-care.
  - upd_mispredict = 0.
  - pred_hit and pred_taken = 0; pred_target = if_pc + 4.
- Lookup: purely combinational from table state, zero latency.
  - No write-to-read bypass: an update in cycle N is visible to lookup from cycle N+1.
- Target arithmetic: tgt = ex_pc + 4 + sign-extended ({ex_offset, 2'b00}) to 32 bits.
  - Modulo 2^32; wrap-around is silent.
  - Example: ex_pc = 0xFFFFFFFC, offset = 0x0000 gives tgt = 0x00000000.
- Update at clk rising edge when ex_valid = 1 and flush_all = 0. Let i = index(ex_pc), t = tag(ex_pc), hit_u = valid[i] & tag[i] == t.
  - hit_u and ex_taken: counter saturating-increment (max 2^CNT_W-1); target[i] = tgt.
  - hit_u and not ex_taken: counter saturating-decrement (min 0); target unchanged.
  - Miss and ex_taken: allocate, overwriting any existing entry. Set valid = 1, tag = t, target = tgt, counter = 2^(CNT_W-1) (weakly taken; 1 when CNT_W = 1).
  - Miss and not ex_taken: no table change.
- upd_mispredict:
  - Next cycle = ex_valid & !flush_all & ((hit_u & counter_MSB_before) != ex_taken).
  - Otherwise 0 next cycle.
  - A taken-branch target mismatch on hit also sets it.
- flush_all = 1 at an edge:
  - All valid bits clear.
  - A same-cycle update is discarded; flush has priority.
  - upd_mispredict = 0 next cycle.
- Same-edge lookup and update to the same index: lookup in that cycle reflects the pre-update state.
- Reset mid-operation: immediate table invalidation, independent of clk; no partial write survives.
- Only one update per cycle; no internal stall or backpressure.

Test Plan:
- Reset, then if_pc = 0xBFC00000 → pred_hit = 0, pred_taken = 0, pred_target = 0xBFC00004, upd_mispredict = 0.
- Cold miss train:
  - Stimulus: ex_valid, ex_pc = 0xBFC00010, ex_offset = 0x0004, ex_taken = 1.
  - Next cycle: upd_mispredict = 1.
  - Lookup if_pc = 0xBFC00010 → hit, taken, target 0xBFC00024, counter = 2.
- Saturation/hysteresis (CNT_W = 2), same branch:
  - Two more taken updates → counter 3.
  - One not-taken update → counter 2, still predicts taken.
  - Second not-taken update → counter 1, pred_taken = 0, pred_target = 0xBFC00014.
  - Further not-taken updates → floor 0.
- Negative offset wrap:
  - ex_pc = 0x00000000, ex_offset = 0xFFFF, taken → stored target 0x00000000.
  - ex_pc = 0xFFFFFFF8, ex_offset = 0x0001 → target 0x00000000.
- Aliasing (IDX_W = 6, TAG_W = 8):
  - Train 0x00000100 taken, then 0x00004100 taken (same index, different tag).
  - Lookup 0x00000100 → pred_hit = 0.
  - Lookup 0x00004100 → hit.
  - A not-taken update to an unallocated PC leaves the table unchanged.
- Flush/collision:
  - flush_all = 1 together with ex_valid taken update → all lookups miss next cycle, upd_mispredict = 0.
  - Same-edge update and lookup to the same index → lookup shows old entry.
  - Assert resetn low mid-cycle → pred_hit drops to 0 without a clock edge.

Source files
------------

// File: rtl/btb_predictor.sv
// Direct-mapped branch target buffer with per-entry saturating direction counters.
// Lookup is combinational from table state; EX-side training happens on the clock edge.
module btb_predictor #(
    parameter int unsigned IDX_W = 6,
    parameter int unsigned TAG_W = 8,
    parameter int unsigned CNT_W = 2
) (
    input  logic        clk,
    input  logic        resetn,
    input  logic [31:0] if_pc,
    output logic        pred_hit,
    output logic        pred_taken,
    output logic [31:0] pred_target,
    input  logic        ex_valid,
    input  logic [31:0] ex_pc,
    input  logic [15:0] ex_offset,
    input  logic        ex_taken,
    input  logic        flush_all,
    output logic        upd_mispredict
);

    localparam int unsigned ENTRIES = 1 << IDX_W;
    localparam logic [CNT_W-1:0] CNT_MAX  = '1;
    localparam logic [CNT_W-1:0] CNT_MIN  = '0;
    localparam logic [CNT_W-1:0] CNT_INIT = CNT_W'(1 << (CNT_W - 1));

    // Table storage: valid and counters are reset, tag and target are plain data.
    logic             valid_q [ENTRIES];
    logic [CNT_W-1:0] cnt_q   [ENTRIES];
    logic [TAG_W-1:0] tag_q   [ENTRIES];
    logic [31:0]      tgt_q   [ENTRIES];
    logic             upd_mispredict_q;

    logic [IDX_W-1:0] if_idx;
    logic [TAG_W-1:0] if_tag;
    logic [IDX_W-1:0] ex_idx;
    logic [TAG_W-1:0] ex_tag;
    logic [31:0]      ex_tgt;

    logic             ex_hit_c;
    logic             ex_pred_c;
    logic             ex_mis_c;
    logic             ex_cnt_we_c;
    logic             ex_tgt_we_c;
    logic [CNT_W-1:0] ex_cnt_next_c;

    assign if_idx = if_pc[IDX_W+1:2];
    assign if_tag = if_pc[IDX_W+TAG_W+1:IDX_W+2];
    assign ex_idx = ex_pc[IDX_W+1:2];
    assign ex_tag = ex_pc[IDX_W+TAG_W+1:IDX_W+2];

    // Branch target: PC + 4 + sign-extended word offset, wrapping modulo 2^32.
    assign ex_tgt = ex_pc + 32'd4 + {{14{ex_offset[15]}}, ex_offset, 2'b00};

    // Fetch-side lookup; reflects table contents before any same-edge update.
    always_comb begin
        pred_hit    = 1'b0;
        pred_taken  = 1'b0;
        pred_target = if_pc + 32'd4;
        if (valid_q[if_idx] && (tag_q[if_idx] == if_tag)) begin
            pred_hit   = 1'b1;
            pred_taken = cnt_q[if_idx][CNT_W-1];
            if (pred_taken) begin
                pred_target = tgt_q[if_idx];
            end
        end
    end

    // EX-side training decision: hit check, counter step, write enables, misprediction.
    always_comb begin
        ex_hit_c      = valid_q[ex_idx] && (tag_q[ex_idx] == ex_tag);
        ex_pred_c     = ex_hit_c && cnt_q[ex_idx][CNT_W-1];
        ex_mis_c      = (ex_pred_c != ex_taken)
                        || (ex_hit_c && ex_taken && (tgt_q[ex_idx] != ex_tgt));
        ex_cnt_next_c = cnt_q[ex_idx];
        ex_cnt_we_c   = 1'b0;
        ex_tgt_we_c   = 1'b0;
        if (ex_valid && !flush_all) begin
            if (ex_hit_c) begin
                ex_cnt_we_c = 1'b1;
                if (ex_taken) begin
                    ex_tgt_we_c = 1'b1;
                    if (cnt_q[ex_idx] != CNT_MAX) begin
                        ex_cnt_next_c = cnt_q[ex_idx] + CNT_W'(1);
                    end
                end else if (cnt_q[ex_idx] != CNT_MIN) begin
                    ex_cnt_next_c = cnt_q[ex_idx] - CNT_W'(1);
                end
            end else if (ex_taken) begin
                ex_cnt_we_c   = 1'b1;
                ex_tgt_we_c   = 1'b1;
                ex_cnt_next_c = CNT_INIT;
            end
        end
    end

    // Valid bits, counters and the misprediction flag; flush beats a same-cycle update.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            for (int i = 0; i < int'(ENTRIES); i++) begin
                valid_q[i] <= 1'b0;
                cnt_q[i]   <= '0;
            end
            upd_mispredict_q <= 1'b0;
        end else if (flush_all) begin
            for (int i = 0; i < int'(ENTRIES); i++) begin
                valid_q[i] <= 1'b0;
            end
            upd_mispredict_q <= 1'b0;
        end else begin
            upd_mispredict_q <= ex_valid && ex_mis_c;
            if (ex_cnt_we_c) begin
                valid_q[ex_idx] <= 1'b1;
                cnt_q[ex_idx]   <= ex_cnt_next_c;
            end
        end
    end

    // Tag and target payload; only meaningful behind a set valid bit, so no reset.
    always_ff @(posedge clk) begin
        if (ex_tgt_we_c) begin
            tag_q[ex_idx] <= ex_tag;
            tgt_q[ex_idx] <= ex_tgt;
        end
    end

    assign upd_mispredict = upd_mispredict_q;

endmodule

// File: tb/tb_btb_predictor.sv
// Directed self-checking bench for btb_predictor (default parameters).
module tb_btb_predictor;

    logic        clk;
    logic        resetn;
    logic [31:0] if_pc;
    logic        pred_hit;
    logic        pred_taken;
    logic [31:0] pred_target;
    logic        ex_valid;
    logic [31:0] ex_pc;
    logic [15:0] ex_offset;
    logic        ex_taken;
    logic        flush_all;
    logic        upd_mispredict;

    int errors = 0;
    int checks = 0;

    btb_predictor dut (
        .clk            (clk),
        .resetn         (resetn),
        .if_pc          (if_pc),
        .pred_hit       (pred_hit),
        .pred_taken     (pred_taken),
        .pred_target    (pred_target),
        .ex_valid       (ex_valid),
        .ex_pc          (ex_pc),
        .ex_offset      (ex_offset),
        .ex_taken       (ex_taken),
        .flush_all      (flush_all),
        .upd_mispredict (upd_mispredict)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Advance past the next rising edge and settle.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // One EX-side training cycle; inputs are dropped again after the edge.
    task automatic upd(input logic [31:0] pc, input logic [15:0] off, input logic tk);
        ex_valid  = 1'b1;
        ex_pc     = pc;
        ex_offset = off;
        ex_taken  = tk;
        tick();
        ex_valid  = 1'b0;
    endtask

    task automatic look(input logic [31:0] pc);
        if_pc = pc;
        #1;
    endtask

    initial begin
        resetn    = 1'b0;
        if_pc     = 32'hBFC0_0000;
        ex_valid  = 1'b0;
        ex_pc     = 32'h0;
        ex_offset = 16'h0;
        ex_taken  = 1'b0;
        flush_all = 1'b0;

        // Reset state
        repeat (2) tick();
        check("rst_hit", 32'(pred_hit), 32'd0);
        check("rst_taken", 32'(pred_taken), 32'd0);
        check("rst_target", pred_target, 32'hBFC0_0004);
        check("rst_mis", 32'(upd_mispredict), 32'd0);
        @(negedge clk);
        resetn = 1'b1;
        tick();
        check("post_rst_hit", 32'(pred_hit), 32'd0);

        // Cold miss, taken: allocate weakly taken
        upd(32'hBFC0_0010, 16'h0004, 1'b1);
        check("cold_mis", 32'(upd_mispredict), 32'd1);
        look(32'hBFC0_0010);
        check("cold_hit", 32'(pred_hit), 32'd1);
        check("cold_taken", 32'(pred_taken), 32'd1);
        check("cold_target", pred_target, 32'hBFC0_0024);

        // Two taken updates saturate at 3
        upd(32'hBFC0_0010, 16'h0004, 1'b1);
        check("tk2_mis", 32'(upd_mispredict), 32'd0);
        upd(32'hBFC0_0010, 16'h0004, 1'b1);
        check("tk3_mis", 32'(upd_mispredict), 32'd0);

        // Not-taken to 2: still taken
        upd(32'hBFC0_0010, 16'h0004, 1'b0);
        check("nt1_mis", 32'(upd_mispredict), 32'd1);
        check("nt1_taken", 32'(pred_taken), 32'd1);
        check("nt1_target", pred_target, 32'hBFC0_0024);

        // Not-taken to 1: predicts fall-through
        upd(32'hBFC0_0010, 16'h0004, 1'b0);
        check("nt2_mis", 32'(upd_mispredict), 32'd1);
        check("nt2_hit", 32'(pred_hit), 32'd1);
        check("nt2_taken", 32'(pred_taken), 32'd0);
        check("nt2_target", pred_target, 32'hBFC0_0014);

        // Down to 0 and held at the floor
        upd(32'hBFC0_0010, 16'h0004, 1'b0);
        check("nt3_mis", 32'(upd_mispredict), 32'd0);
        upd(32'hBFC0_0010, 16'h0004, 1'b0);
        check("nt4_mis", 32'(upd_mispredict), 32'd0);
        check("floor_taken", 32'(pred_taken), 32'd0);

        // From 0: one taken gives 1 (not taken), second gives 2 (taken)
        upd(32'hBFC0_0010, 16'h0004, 1'b1);
        check("up1_mis", 32'(upd_mispredict), 32'd1);
        check("up1_taken", 32'(pred_taken), 32'd0);
        upd(32'hBFC0_0010, 16'h0004, 1'b1);
        check("up2_mis", 32'(upd_mispredict), 32'd1);
        check("up2_taken", 32'(pred_taken), 32'd1);
        check("up2_target", pred_target, 32'hBFC0_0024);

        // Predicted taken, taken, but to a different target
        upd(32'hBFC0_0010, 16'h0008, 1'b1);
        check("tgt_mis", 32'(upd_mispredict), 32'd1);
        check("tgt_new", pred_target, 32'hBFC0_0034);

        // Negative offset and wrap-around targets
        upd(32'h0000_0000, 16'hFFFF, 1'b1);
        look(32'h0000_0000);
        check("neg_hit", 32'(pred_hit), 32'd1);
        check("neg_target", pred_target, 32'h0000_0000);
        upd(32'hFFFF_FFF8, 16'h0001, 1'b1);
        look(32'hFFFF_FFF8);
        check("wrap1_target", pred_target, 32'h0000_0000);
        upd(32'hFFFF_FFFC, 16'h0000, 1'b1);
        look(32'hFFFF_FFFC);
        check("wrap2_target", pred_target, 32'h0000_0000);

        // Aliasing: same index, different tag
        upd(32'h0000_0100, 16'h0010, 1'b1);
        upd(32'h0000_4100, 16'h0020, 1'b1);
        look(32'h0000_0100);
        check("alias_old_hit", 32'(pred_hit), 32'd0);
        look(32'h0000_4100);
        check("alias_new_hit", 32'(pred_hit), 32'd1);
        check("alias_new_target", pred_target, 32'h0000_4184);

        // Not-taken on an unallocated PC leaves the table alone
        upd(32'h0000_0200, 16'h0010, 1'b0);
        check("nt_miss_mis", 32'(upd_mispredict), 32'd0);
        check("nt_miss_keep", 32'(pred_hit), 32'd1);
        look(32'h0000_0200);
        check("nt_miss_noalloc", 32'(pred_hit), 32'd0);

        // Flush with a same-cycle taken update: flush wins
        flush_all = 1'b1;
        upd(32'h0000_0300, 16'h0004, 1'b1);
        flush_all = 1'b0;
        check("flush_mis", 32'(upd_mispredict), 32'd0);
        look(32'h0000_0300);
        check("flush_upd_hit", 32'(pred_hit), 32'd0);
        look(32'hBFC0_0010);
        check("flush_a_hit", 32'(pred_hit), 32'd0);
        check("flush_a_target", pred_target, 32'hBFC0_0014);
        look(32'h0000_4100);
        check("flush_b_hit", 32'(pred_hit), 32'd0);

        // Same-edge update and lookup: old entry until the edge
        @(negedge clk);
        if_pc     = 32'h0000_0800;
        ex_valid  = 1'b1;
        ex_pc     = 32'h0000_0800;
        ex_offset = 16'h0010;
        ex_taken  = 1'b1;
        #1;
        check("coll_pre_hit", 32'(pred_hit), 32'd0);
        check("coll_pre_target", pred_target, 32'h0000_0804);
        tick();
        ex_valid = 1'b0;
        check("coll_post_hit", 32'(pred_hit), 32'd1);
        check("coll_post_target", pred_target, 32'h0000_0844);
        check("coll_mis", 32'(upd_mispredict), 32'd1);

        // Asynchronous reset mid-cycle
        #2;
        resetn = 1'b0;
        #1;
        check("arst_hit", 32'(pred_hit), 32'd0);
        check("arst_target", pred_target, 32'h0000_0804);
        check("arst_mis", 32'(upd_mispredict), 32'd0);
        @(negedge clk);
        resetn = 1'b1;
        tick();
        check("arst_after_hit", 32'(pred_hit), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
